// File: rtl/div_iter.sv
// Iterative 32-bit radix-2 restoring divider for DIV/DIVU.
// Fixed 33-cycle latency; the result is held while the request stays high.
module div_iter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_begin,
  input  logic        div_sign,
  input  logic [31:0] div_op1,
  input  logic [31:0] div_op2,
  output logic [31:0] div_result,
  output logic [31:0] div_remainder,
  output logic        div_end
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        qSign_q, qSign_d;
  logic        rSign_q, rSign_d;
  logic        zero_q, zero_d;
  logic [31:0] result_q, result_d;
  logic [31:0] remain_q, remain_d;

  logic [33:0] shifted;
  logic [33:0] diff;
  logic [32:0] remNext;
  logic [31:0] quoNext;

  // One restoring step: shift {rem, dividend} left, then trial-subtract.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {2'b00, dvsr_q};
    if (diff[33]) begin
      remNext = shifted[32:0];
      quoNext = {quo_q[30:0], 1'b0};
    end else begin
      remNext = diff[32:0];
      quoNext = {quo_q[30:0], 1'b1};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    qSign_d  = qSign_q;
    rSign_d  = rSign_q;
    zero_d   = zero_q;
    result_d = result_q;
    remain_d = remain_q;
    case (state_q)
      IDLE: begin
        if (div_begin) begin
          state_d = BUSY;
          dvsr_d  = (div_sign && div_op2[31]) ? -div_op2 : div_op2;
          quo_d   = (div_sign && div_op1[31]) ? -div_op1 : div_op1;
          rem_d   = '0;
          cnt_d   = 5'd31;
          qSign_d = div_sign & (div_op1[31] ^ div_op2[31]);
          rSign_d = div_sign & div_op1[31];
          zero_d  = (div_op2 == 32'd0);
        end
      end
      BUSY: begin
        if (!div_begin) begin
          state_d = IDLE;
        end else begin
          rem_d = remNext;
          quo_d = quoNext;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            state_d = DONE;
            cnt_d   = 5'd0;
            // Divide by zero yields all ones; the remainder path already returns op1.
            if (zero_q)       result_d = 32'hFFFF_FFFF;
            else if (qSign_q) result_d = -quoNext;
            else              result_d = quoNext;
            remain_d = rSign_q ? -remNext[31:0] : remNext[31:0];
          end
        end
      end
      DONE: begin
        if (!div_begin) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      qSign_q  <= 1'b0;
      rSign_q  <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      qSign_q  <= qSign_d;
      rSign_q  <= rSign_d;
      zero_q   <= zero_d;
      result_q <= result_d;
      remain_q <= remain_d;
    end
  end

  assign div_result    = result_q;
  assign div_remainder = remain_q;
  assign div_end       = (state_q == DONE);

endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit radix-2 divider that serves the execute stage's divide request handshake (`div_begin` / `div_end`) for DIV and DIVU. It receives operands from the EXE stage and returns the quotient (written to LO) and the remainder (written to HI). It answers in a fixed 33 cycles and holds the result for as long as the request is held.

## Interface
No parameters; all widths are fixed at 32 bits.

- `clk` in 1: single clock; all state updates on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `div_begin` in 1: request. Held high by EXE for the entire operation, until EXE accepts the result.
- `div_sign` in 1: 1 = signed (DIV), 0 = unsigned (DIVU). Sampled only at start.
- `div_op1` in 32: dividend (rs). Sampled only at start.
- `div_op2` in 32: divisor (rt). Sampled only at start.
- `div_result` out 32: quotient.
- `div_remainder` out 32: remainder.
- `div_end` out 1: result valid; EXE completes on this signal.

## Operation
- State machine: IDLE, BUSY, DONE.
- **IDLE → BUSY** when `div_begin=1`. On that edge:
  - capture `|op1|` and `|op2|` (magnitudes only when `div_sign=1`; raw values otherwise);
  - capture quotient sign = `op1[31]^op2[31]` and remainder sign = `op1[31]`, both forced to 0 when unsigned;
  - clear the 33-bit partial remainder;
  - load the iteration counter with 31.
- **BUSY, each cycle** (restoring step): shift `{rem, dividend}` left by 1, then trial-subtract the divisor magnitude from the 33-bit remainder.
  - Non-negative difference: keep the difference and shift in quotient bit 1.
  - Otherwise: keep the remainder and shift in 0.
  - The counter decrements each cycle. BUSY → DONE on the edge that performs the step with counter = 0, which is the 32nd step.
- **On the DONE-entry edge**: load `div_result` and `div_remainder` with the sign-corrected values. Negate the quotient if its sign flag is set; negate the remainder if its sign flag is set.
- **DONE**: `div_end=1` and outputs stay stable while `div_begin=1`. DONE → IDLE on the first cycle with `div_begin=0`.
- **Abort**: `div_begin=0` while in BUSY → IDLE on the next edge. No output change and no `div_end` pulse. This case covers a pipeline flush on an exception.
- **Divide by zero** (op2 = 0), decided result for both signed and unsigned:
  - `div_result = 32'hFFFF_FFFF`;
  - `div_remainder = op1` as originally presented;
  - latency unchanged.
- **Signed overflow**: `0x8000_0000 / 0xFFFF_FFFF` gives `div_result = 0x8000_0000` and `div_remainder = 0`. This falls out of the magnitude path; it needs no special case.
- **Outputs in IDLE and BUSY**: `div_result` and `div_remainder` hold the last completed result; `div_end=0`.
- **Back-to-back requests**: the requester deasserts `div_begin` for at least one cycle between two divides. A level held continuously is one request.

## Timing
- **Reset**: `resetn=0` forces, asynchronously, state = IDLE, counter = 0, `div_end=0`, `div_result=0`, `div_remainder=0`. This applies at any time, including mid-BUSY.
- **Start**: `div_begin` first high in cycle 0, with the divider in IDLE → state BUSY in cycle 1.
- **Latency**: `div_end` is high from cycle 33, after 32 BUSY cycles (1–32).
- **Hold**: `div_end` stays high in cycle 33 and every following cycle in which `div_begin=1`.
- **Release**: `div_begin` low in cycle k (k ≥ 34) → `div_end` low in cycle k+1, state IDLE.
- **Restart**: a new start is possible in the cycle after `div_begin` has been seen low.
- `div_end` is a registered state decode, with no combinational path from any input.
- **Operand stability**: operand changes after cycle 0 have no effect.

## Test plan
- **Unsigned**: `div_sign=0`, `op1=100`, `op2=7`, `div_begin` held → `div_end` first high in cycle 33; `div_result=14`, `div_remainder=2`; outputs stable for 5 extra held cycles; `div_end` drops one cycle after `div_begin` drops.
- **Signed sign combinations**: `div_sign=1`.
  - `-7/2` → q=`0xFFFF_FFFD`, r=`0xFFFF_FFFF`.
  - `7/-2` → q=`0xFFFF_FFFD`, r=1.
  - `-7/-2` → q=3, r=`0xFFFF_FFFF`.
- **Corner values**:
  - `0x8000_0000 / 0xFFFF_FFFF` signed → q=`0x8000_0000`, r=0.
  - Same operands unsigned → q=0, r=`0x8000_0000`.
  - `0xFFFF_FFFF / 1` unsigned → q=`0xFFFF_FFFF`, r=0.
- **Divide by zero**: `op1=0x1234_5678`, `op2=0`, both signed and unsigned → q=`0xFFFF_FFFF`, r=`0x1234_5678`, `div_end` in cycle 33.
- **Abort then restart**: drop `div_begin` in cycle 10 → no `div_end`, and the previous result is retained. Re-request `100/7` in cycle 12 → `div_end` in cycle 45 with q=14, r=2.
- **Reset mid-operation**: assert `resetn=0` asynchronously in cycle 20 of a divide → outputs 0 and `div_end=0` immediately. Release reset and issue a request → full 33-cycle latency and a correct result. Also run a random 10k-vector signed/unsigned comparison against a reference model.
